sync_debounce: RTL and testbench



---
 rtl/debounce_chan.sv | 91 +++++++++
 rtl/sync_debounce.sv | 59 +++++
 tb/tb_sync_debounce.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/debounce_chan.sv
// -----------------------------------------------------------------------------
// debounce_chan -- one input channel of the sync_debounce block.
//
// A raw asynchronous bit is brought into the clk domain through a
// SYNC_STAGES-deep synchronizer. The last synchronizer stage must then differ
// from the current debounced level for DEBOUNCE_CYCLES consecutive edges
// before the level accepts it. A rise or fall pulse is registered on the
// edge where the level changes.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   raw_i     in   raw asynchronous input bit
//   level_o   out  debounced level
//   rise_o    out  one-cycle pulse when level_o goes 0->1
//   fall_o    out  one-cycle pulse when level_o goes 1->0
//   change_o  out  next-state of (rise_o | fall_o), for a registered
//                  aggregate in the parent
// -----------------------------------------------------------------------------
module debounce_chan #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic change_o
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   synced;

  // Only the last synchronizer stage is allowed to feed logic.
  assign synced = sync_q[SYNC_STAGES-1];

  // NOTE: every variable gets a default at the top of always_comb, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (synced == level_q) begin
      // Agreement (or a bounce back) restarts the filter from zero.
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      // Accepting the new value also clears the counter, so it never wraps.
      level_d = synced;
      cnt_d   = '0;
      rise_d  = synced;
      fall_d  = ~synced;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, which is what makes the shift register a real chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {SYNC_STAGES{RESET_VAL}};
      cnt_q   <= '0;
      level_q <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o  = level_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign change_o = rise_d | fall_d;

endmodule

// File: rtl/sync_debounce.sv
// -----------------------------------------------------------------------------
// sync_debounce -- WIDTH independent channels of synchronizer, debounce filter
// and edge detector, plus a registered "something changed" flag.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   i           in   [WIDTH] raw asynchronous inputs
//   o           out  [WIDTH] debounced levels
//   rise        out  [WIDTH] one-cycle pulse when o[k] goes 0->1
//   fall        out  [WIDTH] one-cycle pulse when o[k] goes 1->0
//   any_change  out  registered OR of rise|fall, same cycle as the pulses
// -----------------------------------------------------------------------------
module sync_debounce #(
  parameter int   WIDTH           = 4,
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_change
);

  logic [WIDTH-1:0] change_d;
  logic             any_change_q;

  for (genvar k = 0; k < WIDTH; k++) begin : g_chan
    debounce_chan #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (RESET_VAL)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw_i   (i[k]),
      .level_o (o[k]),
      .rise_o  (rise[k]),
      .fall_o  (fall[k]),
      .change_o(change_d[k])
    );
  end

  // Registered from the channels' next-state pulses so it lines up with them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_change_q <= 1'b0;
    end else begin
      any_change_q <= |change_d;
    end
  end

  assign any_change = any_change_q;

endmodule

// File: tb/tb_sync_debounce.sv
// -----------------------------------------------------------------------------
// tb_sync_debounce -- directed bench for sync_debounce with WIDTH=4,
// SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_VAL=0, 10 ns clock.
//
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after each
// rising edge. A value applied this way is sampled by the next edge (edge 1);
// the debounced level accepts it on edge SYNC_STAGES+DEBOUNCE_CYCLES = 6,
// i.e. five edges after the sampling edge, together with its pulse.
// -----------------------------------------------------------------------------
module tb_sync_debounce;

  localparam int WIDTH = 4;
  localparam int SYNC  = 2;
  localparam int DEB   = 4;
  localparam int LAT   = SYNC + DEB;  // edges from apply to acceptance

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] i;
  logic [WIDTH-1:0] o, rise, fall;
  logic             any_change;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [WIDTH-1:0] i;
    logic [WIDTH-1:0] o;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             any;
  } vec_t;

  vec_t vecs[$];

  sync_debounce #(
    .WIDTH          (WIDTH),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .RESET_VAL      (1'b0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i         (i),
    .o         (o),
    .rise      (rise),
    .fall      (fall),
    .any_change(any_change)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [12:0] act,
                       input logic [12:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: o/rise/fall/any got %b_%b_%b_%b required %b_%b_%b_%b",
               name, act[12:9], act[8:5], act[4:1], act[0],
               exp[12:9], exp[8:5], exp[4:1], exp[0]);
    end
  endtask

  function automatic logic [12:0] outs();
    return {o, rise, fall, any_change};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Appends the vectors for holding iv from debounced level old_o: LAT-1 quiet
  // edges, the acceptance edge with its pulses, and one edge showing the
  // pulses have cleared.
  task automatic add_phase(input logic [WIDTH-1:0] iv,
                           input logic [WIDTH-1:0] old_o);
    vec_t v;
    logic [WIDTH-1:0] r, f;
    r = iv & ~old_o;
    f = old_o & ~iv;
    for (int e = 1; e < LAT; e++) begin
      v = '{i: iv, o: old_o, rise: '0, fall: '0, any: 1'b0};
      vecs.push_back(v);
    end
    v = '{i: iv, o: iv, rise: r, fall: f, any: |(r | f)};
    vecs.push_back(v);
    v = '{i: iv, o: iv, rise: '0, fall: '0, any: 1'b0};
    vecs.push_back(v);
  endtask

  initial begin
    // ---------------- reset: outputs held low regardless of clk -------------
    rst_n = 1'b0;
    i     = 4'hF;
    #1;
    check("reset_t0", outs(), 13'b0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("reset_clk%0d", c), outs(), 13'b0);
    end
    i = 4'h0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("idle%0d", c), outs(), 13'b0);
    end

    // ---------------- clean step on channel 0 (table) ----------------------
    vecs.delete();
    add_phase(4'b0001, 4'b0000);
    for (int n = 0; n < vecs.size(); n++) begin
      i = vecs[n].i;
      tick();
      check($sformatf("step0_e%0d", n + 1), outs(),
            {vecs[n].o, vecs[n].rise, vecs[n].fall, vecs[n].any});
    end

    // ---------------- bounce on channel 1 (hand sequence) ------------------
    // Toggling never persists long enough, and counts must not accumulate.
    for (int c = 0; c < 8; c++) begin
      i = (c % 2 == 0) ? 4'b0011 : 4'b0001;
      tick();
      check($sformatf("bounce_t%0d", c), outs(), {4'b0001, 4'b0, 4'b0, 1'b0});
    end
    i = 4'b0011;
    for (int e = 1; e < LAT; e++) begin
      tick();
      check($sformatf("bounce_hold_e%0d", e), outs(),
            {4'b0001, 4'b0, 4'b0, 1'b0});
    end
    tick();
    check("bounce_accept", outs(), {4'b0011, 4'b0010, 4'b0000, 1'b1});
    tick();
    check("bounce_clear", outs(), {4'b0011, 4'b0000, 4'b0000, 1'b0});

    // ---------------- fall on ch2, then simultaneous steps (table) ---------
    vecs.delete();
    add_phase(4'b0111, 4'b0011);  // ch2 settles high
    add_phase(4'b0011, 4'b0111);  // ch2 falls
    add_phase(4'b0000, 4'b0011);  // ch0+ch1 fall together
    add_phase(4'b0101, 4'b0000);  // ch0+ch2 rise together
    for (int n = 0; n < vecs.size(); n++) begin
      i = vecs[n].i;
      tick();
      check($sformatf("tbl_v%0d", n), outs(),
            {vecs[n].o, vecs[n].rise, vecs[n].fall, vecs[n].any});
    end

    // ---------------- reset mid-count on channel 3 -------------------------
    i = 4'b1101;
    for (int e = 1; e <= 3; e++) begin
      tick();
      check($sformatf("mid_pre_e%0d", e), outs(), {4'b0101, 4'b0, 4'b0, 1'b0});
    end
    #2;
    rst_n = 1'b0;  // asserted between edges: must act without a clock
    #1;
    check("mid_async", outs(), 13'b0);
    for (int c = 0; c < 2; c++) begin
      tick();
      check($sformatf("mid_in_rst%0d", c), outs(), 13'b0);
    end
    rst_n = 1'b1;
    for (int e = 1; e < LAT; e++) begin
      tick();
      check($sformatf("mid_post_e%0d", e), outs(), 13'b0);
    end
    tick();
    check("mid_accept", outs(), {4'b1101, 4'b1101, 4'b0000, 1'b1});
    tick();
    check("mid_clear", outs(), {4'b1101, 4'b0000, 4'b0000, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
